dmem_responder: RTL and testbench

Responder (memory) end of the processor's data-memory interface. It accepts one load/store request at a time and holds it for a fixed, programmable number of wait states. It then returns a one-cycle response carrying the read data, or the written data for stores. Its purpose is to give the pipelined core a realistic multi-cycle dmem so the core's stall logic can be exercised. It sits between the core and a word-addressed storage array held inside this block.

---
 rtl/dmem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory end of the core's data-memory interface. Accepts one load/store
// request at a time, holds it for WAIT_CYCLES wait states, then returns a
// single-cycle response carrying the read word (loads) or the written word
// (stores). Gives the pipelined core a multi-cycle dmem for stall testing.
//
// Ports
//   clock         in   1   master clock, rising edge
//   reset         in   1   asynchronous reset, active low
//   req_valid     in   1   request present this cycle
//   req_ready     out  1   responder can accept a request this cycle
//   wren          in   1   1 = store, 0 = load (sampled at acceptance)
//   address_dmem  in  32   word address (sampled at acceptance)
//   data          in  32   store data (sampled at acceptance)
//   resp_valid    out  1   one-cycle response pulse
//   q_dmem        out 32   response data, zero while resp_valid = 0
//   addr_err      out  1   response belongs to an out-of-range address
//
// Parameters
//   ADDR_BITS     word-index width, array depth 2**ADDR_BITS (must be < 32)
//   WAIT_CYCLES   wait states between acceptance and response, 0..15
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    output logic        resp_valid,
    output logic [31:0] q_dmem,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    // Only meaningful when WAIT_CYCLES >= 1; the zero-wait path never loads it.
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // Address is legal when every bit above the word index is zero.
    function automatic logic addr_in_range(input logic [31:0] addr);
        return ((addr >> ADDR_BITS) == 32'd0);
    endfunction

    // FSM and captured request
    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   wren_q, wren_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            data_q, data_d;

    // Registered response outputs
    logic                   resp_valid_q, resp_valid_d;
    logic [31:0]            q_dmem_q, q_dmem_d;
    logic                   addr_err_q, addr_err_d;

    // Storage array (not reset)
    logic [31:0]            mem_q [DEPTH];

    // Datapath helpers
    logic                   accept_s;
    logic                   enter_resp_s;
    logic                   eff_wren_s;
    logic [31:0]            eff_addr_s;
    logic [31:0]            eff_data_s;
    logic                   in_range_s;
    logic [ADDR_BITS-1:0]   idx_s;
    logic                   mem_we_s;
    logic [31:0]            rd_word_s;

    // Ready is forced low while reset is held, otherwise follows IDLE.
    assign req_ready = reset & (state_q == ST_IDLE);
    assign accept_s  = req_valid & req_ready;

    // With zero wait states the acceptance edge is also the edge that enters
    // RESP, so the live inputs must feed the array/response that same edge.
    assign eff_wren_s = (state_q == ST_IDLE) ? wren         : wren_q;
    assign eff_addr_s = (state_q == ST_IDLE) ? address_dmem : addr_q;
    assign eff_data_s = (state_q == ST_IDLE) ? data         : data_q;

    assign in_range_s   = addr_in_range(eff_addr_s);
    assign idx_s        = eff_addr_s[ADDR_BITS-1:0];
    assign enter_resp_s = (accept_s && NO_WAIT) ||
                          ((state_q == ST_WAIT) && (cnt_q == 4'd0));
    assign mem_we_s     = enter_resp_s & eff_wren_s & in_range_s;
    assign rd_word_s    = mem_q[idx_s];

    // State, counter and captured-request registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wren_q  <= 1'b0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state, counter and capture logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wren_d  = wren_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    wren_d = wren;
                    addr_d = address_dmem;
                    data_d = data;
                    if (NO_WAIT) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Counter stops at zero; it is reloaded only on acceptance.
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response values to be registered on the edge that enters RESP
    always_comb begin
        resp_valid_d = 1'b0;
        q_dmem_d     = 32'd0;
        addr_err_d   = 1'b0;
        if (enter_resp_s) begin
            resp_valid_d = 1'b1;
            if (!in_range_s) begin
                addr_err_d = 1'b1;
                q_dmem_d   = 32'd0;
            end else if (eff_wren_s) begin
                q_dmem_d = eff_data_s;
            end else begin
                q_dmem_d = rd_word_s;
            end
        end else begin
            resp_valid_d = 1'b0;
        end
    end

    // Response output registers; they drop back to zero after the pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            q_dmem_q     <= 32'd0;
            addr_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            q_dmem_q     <= q_dmem_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Array write; commits on the edge that enters RESP, never while in reset
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[idx_s] <= eff_data_s;
        end
    end

    assign resp_valid = resp_valid_q;
    assign q_dmem     = q_dmem_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responders (WAIT_CYCLES = 2, 5, 0) share clock and reset. Accepted
// requests are pushed to a scoreboard; responses are popped and compared
// against a reference memory model, including response timing.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int NI = 3;
    localparam int WCS [NI] = '{2, 5, 0};

    typedef struct {
        int          inst;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } req_t;

    logic              clk;
    logic              rst_n;
    logic [NI-1:0]     req_valid;
    logic [NI-1:0]     req_ready;
    logic [NI-1:0]     wren;
    logic [31:0]       addr  [NI];
    logic [31:0]       wdata [NI];
    logic [NI-1:0]     resp_v;
    logic [31:0]       qd    [NI];
    logic [NI-1:0]     aerr;

    int                n_tests;
    int                n_fail;
    int                cyc;
    req_t              sb [$];
    logic [31:0]       mdl [NI][4096];
    logic [NI-1:0]     post_chk;
    int                acc [3];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .ADDR_BITS   (12),
            .WAIT_CYCLES (WCS[g])
        ) u_dut (
            .clock        (clk),
            .reset        (rst_n),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .wren         (wren[g]),
            .address_dmem (addr[g]),
            .data         (wdata[g]),
            .resp_valid   (resp_v[g]),
            .q_dmem       (qd[g]),
            .addr_err     (aerr[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Monitor / scoreboard, sampling on the falling edge
    initial begin : mon
        req_t        e;
        logic [31:0] qe;
        logic        ee;
        logic        inr;
        post_chk = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (resp_v[i]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 32'(i) + 32'd1, 32'd0);
                    end else begin
                        e   = sb.pop_front();
                        inr = ((e.addr >> 12) == 32'd0);
                        ee  = !inr;
                        if (!inr)       qe = 32'd0;
                        else if (e.wren) qe = e.data;
                        else             qe = mdl[i][e.addr[11:0]];
                        check("resp_inst",  32'(i), 32'(e.inst));
                        check("resp_cycle", 32'(cyc), 32'(e.due));
                        check("q_dmem",     qd[i], qe);
                        check("addr_err",   32'(aerr[i]), 32'(ee));
                        check("ready_in_resp", 32'(req_ready[i]), 32'd0);
                        if (inr && e.wren) mdl[i][e.addr[11:0]] = e.data;
                        post_chk[i] = 1'b1;
                    end
                end else if (post_chk[i]) begin
                    check("q_hold_zero",   qd[i], 32'd0);
                    check("err_hold_zero", 32'(aerr[i]), 32'd0);
                    check("ready_after_resp", 32'(req_ready[i]), 32'd1);
                    post_chk[i] = 1'b0;
                end
            end
            if (sb.size() > 0 && cyc > sb[0].due) begin
                check("resp_timeout", 32'(cyc), 32'(sb[0].due));
                void'(sb.pop_front());
            end
            for (int i = 0; i < NI; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.inst = i;
                    e.wren = wren[i];
                    e.addr = addr[i];
                    e.data = wdata[i];
                    e.due  = cyc + 1 + WCS[i];
                    sb.push_back(e);
                end
            end
        end
    end

    // Drive one request and hold it until accepted
    task automatic do_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        req_valid[i] = 1'b1;
        wren[i]      = w;
        addr[i]      = a;
        wdata[i]     = d;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        wren[i]      = 1'b0;
        addr[i]      = 32'hFFFF_FFFF;
        wdata[i]     = 32'hFFFF_FFFF;
    endtask

    // Wait until every outstanding response has been checked
    task automatic wait_done();
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin : stim
        bit ok;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        wren      = '0;
        for (int i = 0; i < NI; i++) begin
            addr[i]  = 32'd0;
            wdata[i] = 32'd0;
        end

        // Reset held: outputs quiet, ready low; ready high right after release
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_ready", 32'(req_ready[i]), 32'd0);
            check("rst_resp",  32'(resp_v[i]),    32'd0);
            check("rst_q",     qd[i],             32'd0);
            check("rst_err",   32'(aerr[i]),      32'd0);
        end
        #2 rst_n = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) check("ready_after_rst", 32'(req_ready[i]), 32'd1);
        @(posedge clk);
        #1;

        // Store then load, WAIT_CYCLES=2
        do_req(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        check("ready_in_wait", 32'(req_ready[0]), 32'd0);
        wait_done();
        @(posedge clk); #1;
        do_req(0, 1'b0, 32'd5, 32'h0);
        wait_done();

        // Back-to-back loads with req_valid held high
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            do_req(0, 1'b1, 32'(k), 32'h1111_0000 + 32'(k));
            wait_done();
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        wren[0]      = 1'b0;
        addr[0]      = 32'd1;
        for (int k = 0; k < 3; k++) begin
            ok = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (req_ready[0]) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check("accept_timeout", 32'd0, 32'd1);
            acc[k] = cyc + 1;
            @(posedge clk); #1;
            if (k < 2) addr[0] = 32'(k + 2);
            else       req_valid[0] = 1'b0;
        end
        wait_done();
        check("acc_gap_1", 32'(acc[1] - acc[0]), 32'd4);
        check("acc_gap_2", 32'(acc[2] - acc[1]), 32'd4);

        // Out-of-range store must not alias onto index 0
        @(posedge clk); #1;
        do_req(0, 1'b1, 32'd0, 32'hA5A5_0000);
        wait_done();
        @(posedge clk); #1;
        do_req(0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF);
        wait_done();
        @(posedge clk); #1;
        do_req(0, 1'b0, 32'd0, 32'h0);
        wait_done();

        // WAIT_CYCLES=5: reset during the second wait cycle aborts the store
        @(posedge clk); #1;
        do_req(1, 1'b1, 32'd9, 32'h0BAD_F00D);
        wait_done();
        @(posedge clk); #1;
        do_req(1, 1'b1, 32'd9, 32'h1234_5678);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(req_ready[1]), 32'd0);
        check("abort_resp",  32'(resp_v[1]),    32'd0);
        #1 rst_n = 1'b1;
        sb.delete();
        post_chk = '0;
        repeat (10) @(negedge clk);
        check("abort_no_pending", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        do_req(1, 1'b0, 32'd9, 32'h0);
        wait_done();

        // WAIT_CYCLES=0: response on the edge right after acceptance
        @(posedge clk); #1;
        do_req(2, 1'b1, 32'd7, 32'h7777_0007);
        wait_done();
        @(posedge clk); #1;
        do_req(2, 1'b0, 32'd7, 32'h0);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
